// File: rtl/jtframe_nvram_pkg.sv
// Shared definitions for the NVRAM ioctl controller: FSM state encoding
// and the byte-space size helper.
package jtframe_nvram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_DUMP_IDLE = 3'd2,
    ST_DUMP_WAIT = 3'd3,
    ST_DUMP_DATA = 3'd4
  } nv_state_t;

  // Number of bytes addressable through the 8-bit port for a given word-address MSB.
  function automatic int unsigned nv_bytes(input int unsigned aw);
    return 32'd1 << (aw + 32'd1);
  endfunction

endpackage

// File: rtl/jtframe_nvram_ioctl_if.sv
// ioctl transfer bus between the frame's hps/ioctl logic (master) and the
// NVRAM controller (slave).
interface jtframe_nvram_ioctl_if;

  logic [25:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_ram;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        din_ok;

  modport master (
    output ioctl_addr, ioctl_dout, ioctl_wr, ioctl_ram, ioctl_upload, ioctl_rd,
    input  ioctl_din, din_ok
  );

  modport slave (
    input  ioctl_addr, ioctl_dout, ioctl_wr, ioctl_ram, ioctl_upload, ioctl_rd,
    output ioctl_din, din_ok
  );

endinterface

// File: rtl/jtframe_nvram_rdpipe.sv
// Read-latency pipe: delays an accepted read request and its range-ok bit by
// RD_LAT cycles so the controller knows when nv_din has settled.
module jtframe_nvram_rdpipe #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic req,
  input  logic req_ok,
  output logic strobe,
  output logic strobe_ok
);

  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] ok_sr;

  // Shift request-valid and range-ok bits; an aborted transfer empties the pipe.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_sr <= '0;
      ok_sr  <= '0;
    end else begin
      vld_sr[0] <= req;
      ok_sr[0]  <= req & req_ok;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_sr[i] <= vld_sr[i-1];
        ok_sr[i]  <= ok_sr[i-1];
      end
    end
  end

  assign strobe    = vld_sr[RD_LAT-1];
  assign strobe_ok = ok_sr[RD_LAT-1];

endmodule

// File: rtl/jtframe_nvram_ioctl.sv
// Host-side controller for the NVRAM 8-bit port: turns ioctl downloads into
// byte writes, ioctl upload requests into timed byte reads, and tracks a
// dirty flag for auto-save.
module jtframe_nvram_ioctl
  import jtframe_nvram_pkg::*;
#(
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  jtframe_nvram_ioctl_if.slave io,
  output logic [AW:0]          nv_addr,
  output logic [7:0]           nv_dout,
  output logic                 nv_we,
  output logic                 nv_sel,
  input  logic [7:0]           nv_din,
  input  logic [1:0]           game_we,
  input  logic                 dirty_clr,
  output logic                 dirty,
  output logic                 busy,
  output logic                 ovf,
  output logic [15:0]          sum
);

  localparam logic [25:0] NV_LIMIT = 26'(nv_bytes(AW));

  nv_state_t   state;
  logic [7:0]  din_data;
  logic        din_pulse;
  logic        rd_ok;
  logic        in_range;
  logic        rd_accept;
  logic        pipe_strobe;
  logic        pipe_ok;
  logic        game_set;

  assign in_range  = (io.ioctl_addr < NV_LIMIT);
  assign rd_accept = (state == ST_DUMP_IDLE) && io.ioctl_upload && io.ioctl_rd;
  // The game only marks NVRAM dirty when it is not being reloaded from the host.
  assign game_set  = (|game_we) && (state != ST_LOAD);

  assign busy         = (state != ST_IDLE);
  assign io.ioctl_din = din_data;
  assign io.din_ok    = din_pulse;

  jtframe_nvram_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (~io.ioctl_upload),
    .req       (rd_accept),
    .req_ok    (in_range),
    .strobe    (pipe_strobe),
    .strobe_ok (pipe_ok)
  );

  // Transfer FSM with all of its registered outputs and the dirty tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      nv_addr   <= '0;
      nv_dout   <= 8'h00;
      nv_we     <= 1'b0;
      nv_sel    <= 1'b0;
      din_data  <= 8'hFF;
      din_pulse <= 1'b0;
      rd_ok     <= 1'b0;
      dirty     <= 1'b0;
      ovf       <= 1'b0;
      sum       <= 16'h0000;
    end else begin
      nv_we     <= 1'b0;
      din_pulse <= 1'b0;
      nv_sel    <= (state != ST_IDLE);

      // Game writes win over an explicit clear in the same cycle.
      if (game_set) begin
        dirty <= 1'b1;
      end else if (dirty_clr) begin
        dirty <= 1'b0;
      end else begin
        dirty <= dirty;
      end

      case (state)
        ST_IDLE: begin
          if (io.ioctl_ram) begin
            state <= ST_LOAD;
            sum   <= 16'h0000;
            ovf   <= 1'b0;
          end else if (io.ioctl_upload) begin
            state <= ST_DUMP_IDLE;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          if (io.ioctl_wr) begin
            if (in_range) begin
              nv_addr <= io.ioctl_addr[AW:0];
              nv_dout <= io.ioctl_dout;
              nv_we   <= 1'b1;
              sum     <= sum + {8'h00, io.ioctl_dout};
            end else begin
              ovf <= 1'b1;
            end
          end
          if (!io.ioctl_ram) begin
            // A fresh load means NVRAM matches the saved image again.
            state <= ST_IDLE;
            dirty <= 1'b0;
          end else begin
            state <= ST_LOAD;
          end
        end

        ST_DUMP_IDLE: begin
          if (!io.ioctl_upload) begin
            state <= ST_IDLE;
          end else if (io.ioctl_rd) begin
            state <= ST_DUMP_WAIT;
            if (in_range) begin
              nv_addr <= io.ioctl_addr[AW:0];
            end
          end else begin
            state <= ST_DUMP_IDLE;
          end
        end

        ST_DUMP_WAIT: begin
          if (!io.ioctl_upload) begin
            state <= ST_IDLE;
          end else if (pipe_strobe) begin
            state <= ST_DUMP_DATA;
            rd_ok <= pipe_ok;
          end else begin
            state <= ST_DUMP_WAIT;
          end
        end

        ST_DUMP_DATA: begin
          if (!io.ioctl_upload) begin
            state <= ST_IDLE;
          end else begin
            // Out-of-range reads never touched memory and return erased-flash data.
            din_data  <= rd_ok ? nv_din : 8'hFF;
            din_pulse <= 1'b1;
            state     <= ST_DUMP_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_nvram_ioctl.sv
// Directed self-checking bench for jtframe_nvram_ioctl at AW=10, RD_LAT=1.
module tb_jtframe_nvram_ioctl;

  localparam int unsigned AW     = 10;
  localparam int unsigned RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   nv_addr;
  logic [7:0]    nv_dout;
  logic          nv_we;
  logic          nv_sel;
  logic [7:0]    nv_din;
  logic [1:0]    game_we;
  logic          dirty_clr;
  logic          dirty;
  logic          busy;
  logic          ovf;
  logic [15:0]   sum;
  logic [7:0]    mem [0:2047];

  int n_total = 0;
  int n_pass  = 0;

  jtframe_nvram_ioctl_if io();

  jtframe_nvram_ioctl #(
    .AW     (AW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (io),
    .nv_addr   (nv_addr),
    .nv_dout   (nv_dout),
    .nv_we     (nv_we),
    .nv_sel    (nv_sel),
    .nv_din    (nv_din),
    .game_we   (game_we),
    .dirty_clr (dirty_clr),
    .dirty     (dirty),
    .busy      (busy),
    .ovf       (ovf),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  // NVRAM 8-bit port model: one-cycle read latency, synchronous byte write.
  always @(posedge clk) begin
    if (nv_we) mem[nv_addr] <= nv_dout;
    nv_din <= mem[nv_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [25:0] a, input logic [7:0] d, input logic exp_we);
    io.ioctl_addr = a;
    io.ioctl_dout = d;
    io.ioctl_wr   = 1'b1;
    tick();
    io.ioctl_wr   = 1'b0;
    check("wr_we", {31'd0, nv_we}, {31'd0, exp_we});
    if (exp_we) begin
      check("wr_addr", {21'd0, nv_addr}, {21'd0, a[AW:0]});
      check("wr_dout", {24'd0, nv_dout}, {24'd0, d});
    end
    tick();
    check("wr_we_off", {31'd0, nv_we}, 32'd0);
  endtask

  task automatic do_rd(input logic [25:0] a, input logic [7:0] exp);
    io.ioctl_addr = a;
    io.ioctl_rd   = 1'b1;
    tick();
    io.ioctl_rd   = 1'b0;
    check("rd_ok_c1", {31'd0, io.din_ok}, 32'd0);
    tick();
    check("rd_ok_c2", {31'd0, io.din_ok}, 32'd0);
    check("rd_we", {31'd0, nv_we}, 32'd0);
    tick();
    check("rd_ok_c3", {31'd0, io.din_ok}, 32'd1);
    check("rd_data", {24'd0, io.ioctl_din}, {24'd0, exp});
    tick();
    check("rd_ok_off", {31'd0, io.din_ok}, 32'd0);
    check("rd_hold", {24'd0, io.ioctl_din}, {24'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[5] = 8'hA5;
    rst = 1'b1;
    io.ioctl_addr = 26'd0; io.ioctl_dout = 8'd0; io.ioctl_wr = 1'b0;
    io.ioctl_ram = 1'b0; io.ioctl_upload = 1'b0; io.ioctl_rd = 1'b0;
    game_we = 2'b00; dirty_clr = 1'b0;
    tick(); tick();
    check("rst_sel", {31'd0, nv_sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_din", {24'd0, io.ioctl_din}, 32'hFF);
    check("rst_dinok", {31'd0, io.din_ok}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_flags", {29'd0, nv_we, dirty, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // Dirty handling in IDLE.
    game_we = 2'b10; tick(); game_we = 2'b00;
    check("dirty_set", {31'd0, dirty}, 32'd1);
    dirty_clr = 1'b0; game_we = 2'b00; tick();
    check("dirty_hold", {31'd0, dirty}, 32'd1);
    dirty_clr = 1'b1; tick(); dirty_clr = 1'b0;
    check("dirty_clr", {31'd0, dirty}, 32'd0);
    game_we = 2'b01; dirty_clr = 1'b1; tick(); game_we = 2'b00; dirty_clr = 1'b0;
    check("dirty_set_wins", {31'd0, dirty}, 32'd1);

    // Load of three bytes including the top address.
    io.ioctl_ram = 1'b1; tick();
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_sel_lag", {31'd0, nv_sel}, 32'd0);
    tick();
    check("load_sel", {31'd0, nv_sel}, 32'd1);
    do_wr(26'd0, 8'h12, 1'b1);
    do_wr(26'd1, 8'h34, 1'b1);
    do_wr(26'd2047, 8'hFF, 1'b1);
    check("load_sum", {16'd0, sum}, 32'h0145);
    check("load_ovf", {31'd0, ovf}, 32'd0);
    io.ioctl_ram = 1'b0; tick();
    check("load_exit_busy", {31'd0, busy}, 32'd0);
    check("load_exit_dirty", {31'd0, dirty}, 32'd0);
    check("load_exit_sel_lag", {31'd0, nv_sel}, 32'd1);
    tick();
    check("load_exit_sel", {31'd0, nv_sel}, 32'd0);

    // Load with an out-of-range byte.
    io.ioctl_ram = 1'b1; tick();
    check("reload_sum_clr", {16'd0, sum}, 32'd0);
    do_wr(26'd3, 8'h10, 1'b1);
    do_wr(26'd2048, 8'h77, 1'b0);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check("ovf_sum", {16'd0, sum}, 32'h0010);
    io.ioctl_ram = 1'b0; tick(); tick();
    check("ovf_sticky", {31'd0, ovf}, 32'd1);

    // ram and upload together: LOAD wins (ovf clears, writes go through).
    io.ioctl_ram = 1'b1; io.ioctl_upload = 1'b1; tick();
    check("prio_ovf_clr", {31'd0, ovf}, 32'd0);
    do_wr(26'd4, 8'h01, 1'b1);
    io.ioctl_ram = 1'b0; io.ioctl_upload = 1'b0; tick(); tick();
    check("prio_idle", {31'd0, busy}, 32'd0);

    // Dumps.
    io.ioctl_upload = 1'b1; tick(); tick();
    check("dump_sel", {31'd0, nv_sel}, 32'd1);
    do_rd(26'd5, 8'hA5);
    do_rd(26'h900, 8'hFF);
    do_rd(26'd1, 8'h34);
    do_rd(26'd0, 8'h12);

    // Abort in DUMP_WAIT.
    io.ioctl_addr = 26'd5; io.ioctl_rd = 1'b1; tick();
    io.ioctl_rd = 1'b0; io.ioctl_upload = 1'b0; tick();
    check("abort_dinok", {31'd0, io.din_ok}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    check("abort_dinok2", {31'd0, io.din_ok}, 32'd0);
    check("abort_sel", {31'd0, nv_sel}, 32'd0);
    check("abort_din_hold", {24'd0, io.ioctl_din}, 32'h12);

    // Reset in mid-LOAD.
    io.ioctl_ram = 1'b1; tick(); tick();
    io.ioctl_addr = 26'd6; io.ioctl_dout = 8'h55; io.ioctl_wr = 1'b1; rst = 1'b1;
    tick();
    check("mrst_sel", {31'd0, nv_sel}, 32'd0);
    check("mrst_we", {31'd0, nv_we}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_din", {24'd0, io.ioctl_din}, 32'hFF);
    rst = 1'b0; io.ioctl_wr = 1'b0; io.ioctl_ram = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
